data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram_pkg.sv | 14 +
 rtl/data_ram_align.sv | 54 +++++
 rtl/data_ram.sv | 130 +++++++++++++
 tb/tb_data_ram.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared width encodings and FSM states for data_ram and its initiators
package data_ram_pkg;

  localparam logic [1:0] WIDTH_B = 2'd0;
  localparam logic [1:0] WIDTH_H = 2'd1;
  localparam logic [1:0] WIDTH_W = 2'd2;
  localparam logic [1:0] WIDTH_R = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/data_ram_align.sv
// rtl/data_ram_align.sv - byte-lane steering for stores, extract/extend for loads, misalignment fault
module data_ram_align
  import data_ram_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_width,
  input  logic        i_extend,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_rd_word,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_rd_data,
  output logic        o_fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rd_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_rd_word[31:16] : i_rd_word[15:0];

  always_comb begin
    o_byte_en = 4'b0000;
    o_wr_word = 32'd0;
    o_rd_data = 32'd0;
    o_fault   = 1'b0;
    case (i_width)
      WIDTH_B: begin
        o_byte_en = 4'b0001 << i_offset;
        o_wr_word = {4{i_wr_data[7:0]}};
        o_rd_data = {{24{i_extend & w_byte[7]}}, w_byte};
      end
      WIDTH_H: begin
        o_fault   = i_offset[0];
        o_byte_en = i_offset[1] ? 4'b1100 : 4'b0011;
        o_wr_word = {2{i_wr_data[15:0]}};
        o_rd_data = {{16{i_extend & w_half[15]}}, w_half};
      end
      WIDTH_W: begin
        o_fault   = (i_offset != 2'b00);
        o_byte_en = 4'b1111;
        o_wr_word = i_wr_data;
        o_rd_data = i_rd_word;
      end
      default: o_fault = 1'b1;
    endcase
    // A faulting access must neither touch memory nor return data.
    if (o_fault) begin
      o_byte_en = 4'b0000;
      o_rd_data = 32'd0;
    end
  end

endmodule

// File: rtl/data_ram.sv
// rtl/data_ram.sv - byte-addressable 32-bit data RAM with configurable ack latency
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] data_in,
  input  logic        extend,
  input  logic [1:0]  width,
  output logic        ack,
  output logic [31:0] data_out,
  output logic        err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        w_ack;
  logic [31:0] r_data_out;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [AW-1:0] w_idx;
  logic [31:0] w_rd_word;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wr_word;
  logic [31:0] w_rd_data;
  logic        w_fault;
  logic        w_unused_addr;

  assign w_idx         = addr[AW+1:2];
  assign w_rd_word     = r_mem[w_idx];
  assign w_unused_addr = ^addr[31:AW+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Zero latency bypasses the FSM entirely so back-to-back accesses run every cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack       = 1'b0;
    if (LATENCY == 0) begin
      w_ack       = req;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
          end else if (r_cnt == 3'd0) begin
            w_ack       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  assign ack = w_ack & ~reset;

  data_ram_align u_align (
    .i_offset  (addr[1:0]),
    .i_width   (width),
    .i_extend  (extend),
    .i_wr_data (data_in),
    .i_rd_word (w_rd_word),
    .o_byte_en (w_byte_en),
    .o_wr_word (w_wr_word),
    .o_rd_data (w_rd_data),
    .o_fault   (w_fault)
  );

  always_ff @(posedge clk) begin
    if (ack && write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wr_word[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_err <= ack & w_fault;
      if (ack && (w_fault || !write)) begin
        r_data_out <= w_rd_data;
      end
    end
  end

  assign data_out = r_data_out;
  assign err      = r_err;

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - directed plus random checks of data_ram at latencies 0, 3 and 2
module tb_data_ram;
  import data_ram_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  req_v;
  logic [31:0] addr;
  logic        write;
  logic [31:0] data_in;
  logic        extend;
  logic [1:0]  width;
  logic        ack_v  [3];
  logic [31:0] dout_v [3];
  logic        err_v  [3];

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mb [3][4096];
  logic [31:0] last_out [3];
  int          lat_tab [3] = '{0, 3, 2};

  data_ram #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .addr(addr), .write(write),
    .data_in(data_in), .extend(extend), .width(width),
    .ack(ack_v[0]), .data_out(dout_v[0]), .err(err_v[0]));

  data_ram #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req_v[1]), .addr(addr), .write(write),
    .data_in(data_in), .extend(extend), .width(width),
    .ack(ack_v[1]), .data_out(dout_v[1]), .err(err_v[1]));

  data_ram #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req_v[2]), .addr(addr), .write(write),
    .data_in(data_in), .extend(extend), .width(width),
    .ack(ack_v[2]), .data_out(dout_v[2]), .err(err_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model works on a flat byte array using the access rules directly.
  task automatic model(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic ext, input logic [1:0] w, output logic f, output logic [31:0] r);
    int b;
    b = int'(a[11:0]);
    f = (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'b00);
    r = last_out[s];
    if (f) begin
      r = 32'd0;
    end else if (wr) begin
      if (w == 2'd0) mb[s][b] = d[7:0];
      else if (w == 2'd1) begin
        b = b & ~1;
        mb[s][b] = d[7:0]; mb[s][b+1] = d[15:8];
      end else begin
        b = b & ~3;
        for (int k = 0; k < 4; k++) mb[s][b+k] = d[8*k +: 8];
      end
    end else begin
      if (w == 2'd0) begin
        r = {24'd0, mb[s][b]};
        if (ext && mb[s][b][7]) r = r | 32'hFFFF_FF00;
      end else if (w == 2'd1) begin
        b = b & ~1;
        r = {16'd0, mb[s][b+1], mb[s][b]};
        if (ext && mb[s][b+1][7]) r = r | 32'hFFFF_0000;
      end else begin
        b = b & ~3;
        r = {mb[s][b+3], mb[s][b+2], mb[s][b+1], mb[s][b]};
      end
    end
    last_out[s] = r;
  endtask

  task automatic access(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic ext, input logic [1:0] w);
    int n;
    logic f;
    logic [31:0] r;
    n = 0;
    @(negedge clk);
    addr = a; write = wr; data_in = d; extend = ext; width = w;
    req_v[s] = 1'b1;
    #1;
    while (ack_v[s] !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("ack_wait_dut%0d", s), n, lat_tab[s]);
    model(s, wr, a, d, ext, w, f, r);
    @(posedge clk);
    #1;
    req_v[s] = 1'b0;
    chk($sformatf("err_dut%0d_a%h", s, a), {31'd0, err_v[s]}, {31'd0, f});
    chk($sformatf("dout_dut%0d_a%h", s, a), dout_v[s], r);
  endtask

  initial begin
    logic [31:0] wv;
    logic [31:0] d;
    reset = 1'b1; req_v = 3'b001;
    addr = 32'd0; write = 1'b0; data_in = 32'd0; extend = 1'b0; width = WIDTH_W;
    for (int s = 0; s < 3; s++) last_out[s] = 32'd0;
    #12;
    chk("rst_ack", {31'd0, ack_v[0]}, 32'd0);
    chk("rst_dout", dout_v[0], 32'd0);
    chk("rst_err", {31'd0, err_v[1]}, 32'd0);
    req_v = 3'b000;
    for (int i = 0; i < 1024; i++) begin
      for (int s = 0; s < 3; s++) begin
        wv = $urandom;
        if (s == 0) u_dut0.r_mem[i] = wv;
        else if (s == 1) u_dut3.r_mem[i] = wv;
        else u_dut2.r_mem[i] = wv;
        for (int k = 0; k < 4; k++) mb[s][4*i+k] = wv[8*k +: 8];
      end
    end
    @(negedge clk);
    reset = 1'b0;

    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, WIDTH_W);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, WIDTH_W);
    chk("raw_word", dout_v[0], 32'hDEADBEEF);

    access(0, 1'b1, 32'h20, 32'h80FF7F01, 1'b0, WIDTH_W);
    access(0, 1'b0, 32'h23, 32'h0, 1'b1, WIDTH_B);
    chk("byte_sx", dout_v[0], 32'hFFFFFF80);
    access(0, 1'b0, 32'h23, 32'h0, 1'b0, WIDTH_B);
    chk("byte_zx", dout_v[0], 32'h00000080);
    access(0, 1'b0, 32'h20, 32'h0, 1'b1, WIDTH_H);
    chk("half_sx", dout_v[0], 32'h00007F01);

    access(1, 1'b1, 32'h30, 32'h11223344, 1'b0, WIDTH_W);
    access(1, 1'b1, 32'h31, 32'h000000AA, 1'b0, WIDTH_B);
    access(1, 1'b0, 32'h30, 32'h0, 1'b0, WIDTH_W);
    chk("byte_merge", dout_v[1], 32'h1122AA44);

    @(negedge clk);
    addr = 32'h40; write = 1'b1; data_in = 32'hCAFEF00D; width = WIDTH_W;
    req_v[1] = 1'b1;
    #1 chk("abort_ack0", {31'd0, ack_v[1]}, 32'd0);
    @(negedge clk);
    req_v[1] = 1'b0;
    #1 chk("abort_ack1", {31'd0, ack_v[1]}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("abort_dout", dout_v[1], last_out[1]);
    access(1, 1'b0, 32'h40, 32'h0, 1'b0, WIDTH_W);

    access(0, 1'b0, 32'h41, 32'h0, 1'b0, WIDTH_H);
    chk("fault_half_dout", dout_v[0], 32'd0);
    @(posedge clk);
    #1 chk("fault_err_pulse", {31'd0, err_v[0]}, 32'd0);
    access(0, 1'b0, 32'h44, 32'h0, 1'b0, WIDTH_W);
    access(0, 1'b1, 32'h44, 32'h5555AAAA, 1'b0, WIDTH_R);
    @(posedge clk);
    #1 chk("fault_r_err_pulse", {31'd0, err_v[0]}, 32'd0);
    access(0, 1'b0, 32'h44, 32'h0, 1'b0, WIDTH_W);

    access(2, 1'b0, 32'h54, 32'h0, 1'b0, WIDTH_W);
    @(negedge clk);
    addr = 32'h50; write = 1'b1; data_in = 32'h12345678; width = WIDTH_W;
    req_v[2] = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ack", {31'd0, ack_v[2]}, 32'd0);
    chk("mid_rst_dout", dout_v[2], 32'd0);
    chk("mid_rst_err", {31'd0, err_v[2]}, 32'd0);
    for (int s = 0; s < 3; s++) last_out[s] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req_v[2] = 1'b0;
    reset = 1'b0;
    access(2, 1'b0, 32'h50, 32'h0, 1'b0, WIDTH_W);

    d = $urandom;
    access(0, 1'b1, 32'h1010, d, 1'b0, WIDTH_W);
    access(0, 1'b0, 32'h0010, 32'h0, 1'b0, WIDTH_W);
    chk("alias", dout_v[0], d);

    for (int i = 0; i < 60; i++) begin
      access($urandom_range(0, 2), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 127)) | (32'($urandom_range(0, 1)) << 12),
             $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
